ctrl_st: RTL and testbench

- Store-side counterpart of the tile load controller.
- After a compute tile finishes, it drains the bit-serial (BS) output buffer and then the bit-parallel (BP) output buffer, in that order, into one ready/valid output stream toward the DMA/AXI write path.
- Issues buffer reads with addresses, absorbs the 1-cycle buffer read latency in a small skid FIFO, tags the final beat, and pulses st_tile_end when the whole tile has been accepted downstream.

---
 rtl/ctrl_pkg.sv | 17 +
 rtl/st_skid_fifo.sv | 54 +++++
 rtl/ctrl_st.sv | 158 +++++++++++++++
 tb/tb_ctrl_st.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types for the tile store controller.
// FSM state encoding and FIFO tag bundle.
package ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD_BS,
    ST_RD_BP,
    ST_DRAIN
  } st_state_e;

  typedef struct packed {
    logic src;
    logic last;
  } st_tag_t;

endpackage

// File: rtl/st_skid_fifo.sv
// Small registered FIFO absorbing output-buffer read latency.
// Head is a register read; an empty FIFO never falls through.
module st_skid_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign count   = cnt_q;
  assign dout    = mem_q[rptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= din;
        wptr_q        <= nxt(wptr_q);
      end
      if (do_pop) rptr_q <= nxt(rptr_q);
      if (do_push && !do_pop) cnt_q <= cnt_q + CW'(1);
      else if (do_pop && !do_push) cnt_q <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/ctrl_st.sv
// Tile store controller: drains BS then BP output buffers
// into one ready/valid stream, tags last beat, pulses tile end.
module ctrl_st
  import ctrl_pkg::*;
#(
  parameter int ST_DATA_W     = 64,
  parameter int BS_OUT_BUF_AW = 10,
  parameter int BP_OUT_BUF_AW = 10,
  parameter int SKID_DEPTH    = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     st_tile_start,
  input  logic [15:0]              bs_st_times,
  input  logic [15:0]              bp_st_times,
  output logic                     bs_out_buf_rd_en,
  output logic [BS_OUT_BUF_AW-1:0] bs_out_buf_rd_addr,
  input  logic [ST_DATA_W-1:0]     bs_out_buf_rd_data,
  output logic                     bp_out_buf_rd_en,
  output logic [BP_OUT_BUF_AW-1:0] bp_out_buf_rd_addr,
  input  logic [ST_DATA_W-1:0]     bp_out_buf_rd_data,
  output logic [ST_DATA_W-1:0]     st_data,
  output logic                     st_src,
  output logic                     st_last,
  output logic                     st_valid,
  input  logic                     st_ready,
  output logic                     st_tile_end,
  output logic                     st_busy
);

  localparam int CW = $clog2(SKID_DEPTH + 1);
  localparam int FW = ST_DATA_W + $bits(st_tag_t);

  st_state_e      state_q, state_d;
  logic [15:0]    bs_n_q, bp_n_q, cnt_q, cnt_d;
  logic           inflight_q, tile_end_q;
  st_tag_t        tag_q, tag_d, head_tag;
  logic [ST_DATA_W-1:0] head_data, rd_data;
  logic [FW-1:0]  din, dout;
  logic [CW-1:0]  fifo_cnt;
  logic [CW:0]    credit;
  logic           fifo_empty, fifo_full;
  logic           pop, issue, in_bs, in_bp, at_end, done;

  assign in_bs  = (state_q == ST_RD_BS);
  assign in_bp  = (state_q == ST_RD_BP);
  assign pop    = st_valid && st_ready;
  assign credit = {1'b0, fifo_cnt} + (CW+1)'(inflight_q)
                - (CW+1)'(pop);
  assign issue  = (in_bs || in_bp)
               && (credit < (CW+1)'(SKID_DEPTH));
  assign at_end = in_bs ? (cnt_q == bs_n_q - 16'd1)
                        : (cnt_q == bp_n_q - 16'd1);

  assign tag_d.src  = in_bp;
  assign tag_d.last = at_end && (in_bp || bp_n_q == 16'd0);

  // Finish once the final beat leaves this cycle or already left.
  assign done = (state_q == ST_DRAIN) && !inflight_q
             && (fifo_empty || (fifo_cnt == CW'(1) && pop));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (st_tile_start) begin
          cnt_d = '0;
          if (bs_st_times != 16'd0)      state_d = ST_RD_BS;
          else if (bp_st_times != 16'd0) state_d = ST_RD_BP;
          else                           state_d = ST_DRAIN;
        end
      end
      ST_RD_BS: begin
        if (issue) begin
          cnt_d = cnt_q + 16'd1;
          if (at_end) begin
            cnt_d   = '0;
            state_d = (bp_n_q != 16'd0) ? ST_RD_BP : ST_DRAIN;
          end
        end
      end
      ST_RD_BP: begin
        if (issue) begin
          cnt_d = cnt_q + 16'd1;
          if (at_end) begin
            cnt_d   = '0;
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bs_n_q     <= '0;
      bp_n_q     <= '0;
      inflight_q <= 1'b0;
      tag_q      <= '0;
      tile_end_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      inflight_q <= issue;
      tile_end_q <= done;
      if (issue) tag_q <= tag_d;
      if (state_q == ST_IDLE && st_tile_start) begin
        bs_n_q <= bs_st_times;
        bp_n_q <= bp_st_times;
      end
    end
  end

  assign rd_data = tag_q.src ? bp_out_buf_rd_data
                             : bs_out_buf_rd_data;
  assign din     = {tag_q, rd_data};

  st_skid_fifo #(
    .DEPTH (SKID_DEPTH),
    .W     (FW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (inflight_q),
    .pop   (pop),
    .din   (din),
    .dout  (dout),
    .count (fifo_cnt),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  always_ff @(posedge clk) begin
    if (rst_n) assert (!(fifo_full && inflight_q && !pop));
  end

  assign {head_tag, head_data} = dout;

  assign bs_out_buf_rd_en   = issue && in_bs;
  assign bp_out_buf_rd_en   = issue && in_bp;
  assign bs_out_buf_rd_addr = in_bs ? cnt_q[BS_OUT_BUF_AW-1:0] : '0;
  assign bp_out_buf_rd_addr = in_bp ? cnt_q[BP_OUT_BUF_AW-1:0] : '0;

  assign st_valid    = !fifo_empty;
  assign st_data     = st_valid ? head_data : '0;
  assign st_src      = st_valid && head_tag.src;
  assign st_last     = st_valid && head_tag.last;
  assign st_tile_end = tile_end_q;
  assign st_busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ctrl_st.sv
// Scoreboard bench for ctrl_st.
// Buffers return tagged words so data encodes source and address.
module tb_ctrl_st;

  logic        clk, rst_n;
  logic        st_tile_start;
  logic [15:0] bs_st_times, bp_st_times;
  logic        bs_en, bp_en;
  logic [9:0]  bs_addr, bp_addr;
  logic [63:0] bs_rd, bp_rd;
  logic [63:0] st_data;
  logic        st_src, st_last, st_valid, st_ready;
  logic        st_tile_end, st_busy;

  ctrl_st dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .st_tile_start      (st_tile_start),
    .bs_st_times        (bs_st_times),
    .bp_st_times        (bp_st_times),
    .bs_out_buf_rd_en   (bs_en),
    .bs_out_buf_rd_addr (bs_addr),
    .bs_out_buf_rd_data (bs_rd),
    .bp_out_buf_rd_en   (bp_en),
    .bp_out_buf_rd_addr (bp_addr),
    .bp_out_buf_rd_data (bp_rd),
    .st_data            (st_data),
    .st_src             (st_src),
    .st_last            (st_last),
    .st_valid           (st_valid),
    .st_ready           (st_ready),
    .st_tile_end        (st_tile_end),
    .st_busy            (st_busy)
  );

  typedef struct {
    logic [63:0] d;
    logic        s;
    logic        l;
  } beat_t;

  beat_t q[$];
  int n_cmp = 0, n_bad = 0;
  int cyc = 0, tile_tag = 0, t0 = 0;
  int first_rd = -1, first_val = -1, te_cyc = -1;
  int te_cnt = 0, beats = 0, dual_rd = 0, max_occ = 0;
  logic        stall_q = 1'b0;
  logic [63:0] hold_d;
  logic [1:0]  hold_t;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] word(logic src, int a, int tag);
    logic [31:0] av;
    av = a;
    return {src ? 16'hBBBB : 16'hAAAA, 16'(tag), 22'h0, av[9:0]};
  endfunction

  always @(posedge clk) begin
    bs_rd <= bs_en ? word(1'b0, int'(bs_addr), tile_tag) : 64'h0;
    bp_rd <= bp_en ? word(1'b1, int'(bp_addr), tile_tag) : 64'h0;
  end

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               tag, obs, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bs_en && bp_en) dual_rd++;
      if ((bs_en || bp_en) && first_rd < 0) first_rd = cyc;
      if (st_valid && first_val < 0) first_val = cyc;
      if (int'(dut.u_fifo.count) > max_occ)
        max_occ = int'(dut.u_fifo.count);
      if (st_tile_end) begin
        te_cnt++;
        te_cyc = cyc;
      end
      if (stall_q) begin
        chk("hold_valid", st_valid, 1);
        chk("hold_data", st_data, hold_d);
        chk("hold_tag", {st_src, st_last}, hold_t);
      end
      stall_q = st_valid && !st_ready;
      hold_d  = st_data;
      hold_t  = {st_src, st_last};
      if (st_valid && st_ready) begin
        beats++;
        chk("sb_nonempty", q.size() != 0, 1);
        if (q.size() != 0) begin
          beat_t e;
          e = q.pop_front();
          chk("beat_data", st_data, e.d);
          chk("beat_src", st_src, e.s);
          chk("beat_last", st_last, e.l);
        end
      end
    end else begin
      stall_q = 1'b0;
    end
  end

  task automatic start_tile(int bs, int bp);
    @(posedge clk);
    #1;
    tile_tag++;
    t0 = cyc;
    first_rd = -1;
    first_val = -1;
    beats = 0;
    for (int i = 0; i < bs; i++)
      q.push_back('{word(1'b0, i, tile_tag), 1'b0,
                    (i == bs - 1) && (bp == 0)});
    for (int i = 0; i < bp; i++)
      q.push_back('{word(1'b1, i, tile_tag), 1'b1, i == bp - 1});
    st_tile_start = 1'b1;
    bs_st_times = 16'(bs);
    bp_st_times = 16'(bp);
    @(posedge clk);
    #1;
    st_tile_start = 1'b0;
  endtask

  task automatic wait_end(int budget, bit toggle);
    int n = 0;
    int te0 = te_cnt;
    while (te_cnt == te0 && n < budget) begin
      @(posedge clk);
      #1;
      if (toggle) st_ready = ~st_ready;
      n++;
    end
    chk("tile_end_seen", te_cnt != te0, 1);
    st_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("single_tile_end", te_cnt, te0 + 1);
    chk("sb_drained", q.size(), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    st_tile_start = 1'b0;
    bs_st_times = '0;
    bp_st_times = '0;
    st_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outs", {bs_en, bs_addr, bp_en, bp_addr, st_data,
                     st_src, st_last, st_valid, st_tile_end,
                     st_busy}, 0);
    rst_n = 1'b1;

    start_tile(4, 3);
    chk("busy_hi", st_busy, 1);
    wait_end(40, 0);
    chk("basic_rd_lat", first_rd - t0, 1);
    chk("basic_val_lat", first_val - t0, 3);
    chk("basic_end_cyc", te_cyc - t0, 10);
    chk("basic_beats", beats, 7);
    chk("busy_lo", st_busy, 0);

    start_tile(5, 5);
    wait_end(100, 1);
    chk("bp_beats", beats, 10);

    start_tile(0, 2);
    wait_end(40, 0);
    chk("z0_beats", beats, 2);
    start_tile(3, 0);
    wait_end(40, 0);
    chk("z1_beats", beats, 3);
    start_tile(0, 0);
    wait_end(40, 0);
    chk("z2_beats", beats, 0);
    chk("z2_end_cyc", te_cyc - t0, 2);

    start_tile(3, 4);
    begin
      int n = 0;
      while (!bp_en && n < 40) begin
        @(posedge clk);
        #1;
        n++;
      end
      chk("saw_rd_bp", bp_en, 1);
    end
    st_tile_start = 1'b1;
    bs_st_times = 16'd9;
    bp_st_times = 16'd9;
    @(posedge clk);
    #1;
    st_tile_start = 1'b0;
    wait_end(60, 0);
    repeat (20) @(posedge clk);
    #1;
    chk("busy_ignored", beats, 7);
    start_tile(1, 1);
    wait_end(40, 0);
    chk("after_busy", beats, 2);

    start_tile(8, 0);
    begin
      int n = 0;
      while (beats < 3 && n < 40) begin
        @(posedge clk);
        n++;
      end
      chk("reached_beat3", beats >= 3, 1);
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_outs", {bs_en, bs_addr, bp_en, bp_addr, st_data,
                        st_src, st_last, st_valid, st_tile_end,
                        st_busy}, 0);
    q.delete();
    rst_n = 1'b1;
    start_tile(2, 2);
    wait_end(40, 0);
    chk("post_rst_lat", first_rd - t0, 1);
    chk("post_rst_beats", beats, 4);

    start_tile(1024, 1024);
    wait_end(2200, 0);
    chk("long_beats", beats, 2048);
    chk("long_end_cyc", te_cyc - t0, 2051);

    chk("dual_rd", dual_rd, 0);
    chk("max_occ_le2", max_occ <= 2, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
